// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared LEGv8 core widths, instruction field positions and fetch state
package core_pkg;

    localparam int OPC_W   = 11;
    localparam int INSTR_W = 32;

    localparam int OPC_HI    = 31;
    localparam int OPC_LO    = 21;
    localparam int B_IMM_HI  = 25;
    localparam int B_IMM_LO  = 0;
    localparam int CB_IMM_HI = 23;
    localparam int CB_IMM_LO = 5;

    localparam int B_IMM_W  = B_IMM_HI - B_IMM_LO + 1;
    localparam int CB_IMM_W = CB_IMM_HI - CB_IMM_LO + 1;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - combinational next-PC selection for B, CBZ, CBNZ and fall-through
module branch_target
    import core_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               jump,
    input  logic               beq,
    input  logic               bne,
    input  logic               zero,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [ADDR_W-1:0] b_off;
    logic [ADDR_W-1:0] cb_off;

    // Word offsets: sign-extend the immediate and scale by 4 so pc stays aligned.
    assign b_off  = {{(ADDR_W-B_IMM_W-2){instr[B_IMM_HI]}},  instr[B_IMM_HI:B_IMM_LO],   2'b00};
    assign cb_off = {{(ADDR_W-CB_IMM_W-2){instr[CB_IMM_HI]}}, instr[CB_IMM_HI:CB_IMM_LO], 2'b00};

    always_comb begin
        next_pc = pc + ADDR_W'(4);
        if (jump) begin
            next_pc = pc + b_off;
        end else if (beq && zero) begin
            next_pc = pc + cb_off;
        end else if (bne && !zero) begin
            next_pc = pc + cb_off;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC holder and req/ack instruction fetch feeding the control decoder
module fetch_unit
    import core_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDR_W-1:0]  pc,
    input  logic               advance,
    input  logic               jump,
    input  logic               beq,
    input  logic               bne,
    input  logic               zero,
    output logic [CNT_W-1:0]   retired
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [ADDR_W-1:0]  next_pc;

    branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
        .pc      (pc_q),
        .instr   (instr_q),
        .jump    (jump),
        .beq     (beq),
        .bne     (bne),
        .zero    (zero),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // ack only matters in FETCH, advance only in HOLD; anything else leaves state untouched.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_HI:OPC_LO];
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic [63:0] pc;
    logic        advance, jump, beq, bne, zero;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .advance     (advance),
        .jump        (jump),
        .beq         (beq),
        .bne         (bne),
        .zero        (zero),
        .retired     (retired)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic adv(input logic j, input logic q, input logic n, input logic z);
        advance = 1'b1;
        jump = j; beq = q; bne = n; zero = z;
        step();
        advance = 1'b0;
        jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        advance = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_ack = 1'b0;
        chk("rst_pc", pc, 64'h0);
        chk("rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_instr", {32'h0, instr}, 64'h0);
        chk("rst_retired", {32'h0, retired}, 64'h0);

        rst = 1'b0;
        chk("c1_req", {63'h0, imem_req}, 64'h1);
        chk("c1_addr", imem_addr, 64'h0);
        fetch(32'hF840_0000);
        chk("c2_valid", {63'h0, instr_valid}, 64'h1);
        chk("c2_opcode", {53'h0, opcode}, {53'h0, 11'b11111000010});
        chk("c2_pc", pc, 64'h0);
        chk("c2_req", {63'h0, imem_req}, 64'h0);

        adv(0, 0, 0, 0);
        chk("seq_pc1", pc, 64'h4);
        chk("seq_valid_drop", {63'h0, instr_valid}, 64'h0);
        fetch(32'h0); adv(0, 0, 0, 0);
        chk("seq_pc2", pc, 64'h8);
        fetch(32'h0); adv(0, 0, 0, 0);
        chk("seq_pc3", pc, 64'hC);
        chk("seq_retired", {32'h0, retired}, 64'd3);

        fetch(32'h0); adv(0, 0, 0, 0);
        chk("pc_10", pc, 64'h10);
        fetch(32'h17FF_FFFE); adv(1, 0, 0, 0);
        chk("b_neg", pc, 64'h8);
        fetch(32'hB400_0060); adv(0, 1, 0, 1);
        chk("cbz_taken", pc, 64'h14);
        fetch(32'hB400_0060); adv(0, 1, 0, 0);
        chk("cbz_not_taken", pc, 64'h18);
        fetch(32'hB500_0040); adv(0, 0, 1, 0);
        chk("cbnz_taken", pc, 64'h20);
        fetch(32'hB400_0060); adv(0, 1, 1, 1);
        chk("beq_prio", pc, 64'h2C);
        chk("br_retired", {32'h0, retired}, 64'd9);

        imem_rdata = 32'hDEAD_BEEF;
        advance = 1'b1; jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_req", {63'h0, imem_req}, 64'h1);
            chk("ws_addr", imem_addr, 64'h2C);
            chk("ws_retired", {32'h0, retired}, 64'd9);
            chk("ws_instr", {32'h0, instr}, 64'hB400_0060);
        end
        advance = 1'b0; jump = 1'b0;
        fetch(32'h8B02_0020);
        chk("ws_latch", {32'h0, instr}, 64'h8B02_0020);
        chk("ws_valid", {63'h0, instr_valid}, 64'h1);
        fetch(32'h1234_5678);
        chk("hold_ack_ign", {32'h0, instr}, 64'h8B02_0020);
        chk("hold_stay", {63'h0, instr_valid}, 64'h1);

        for (int i = 0; i < 5; i++) begin
            adv(0, 0, 0, 0);
            fetch(32'h0);
        end
        chk("pre_rst_pc", pc, 64'h40);
        chk("pre_rst_retired", {32'h0, retired}, 64'd14);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rh_pc", pc, 64'h0);
        chk("rh_valid", {63'h0, instr_valid}, 64'h0);
        chk("rh_retired", {32'h0, retired}, 64'h0);

        adv(0, 0, 0, 0);
        chk("fetch_adv_ign", pc, 64'h0);
        rst = 1'b1;
        fetch(32'hFFFF_FFFF);
        rst = 1'b0;
        chk("rf_instr", {32'h0, instr}, 64'h0);
        chk("rf_valid", {63'h0, instr_valid}, 64'h0);
        chk("rf_req", {63'h0, imem_req}, 64'h1);

        fetch(32'h17FF_FFFF); adv(1, 0, 0, 0);
        chk("wrap_neg", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch(32'h0); adv(0, 0, 0, 0);
        chk("wrap_zero", pc, 64'h0);
        chk("wrap_retired", {32'h0, retired}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main control decoder in the LEGv8 single-cycle core.
- Holds the PC and fetches 32-bit instructions over a req/ack instruction-memory handshake.
- Presents the held instruction and its 11-bit opcode field (instr[31:21]) to the decoder.
- Computes the next PC from the decoder's jump/beq/bne outputs and the ALU zero flag when the datapath signals completion.

Parameters:
- ADDR_W, 64, PC and instruction-memory address width.
- RESET_PC, 64'h0, PC value after reset; must be a multiple of 4.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  fetch address; equals pc.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- instr_valid  output  1  instr/opcode hold a fetched instruction.
- instr  output  32  held instruction word.
- opcode  output  11  instr[31:21]; drives the control decoder input.
- pc  output  ADDR_W  address of the held instruction.
- advance  input  1  datapath has executed the held instruction.
- jump  input  1  unconditional branch (B) from control.
- beq  input  1  CBZ from control.
- bne  input  1  CBNZ from control.
- zero  input  1  ALU zero flag.
- retired  output  CNT_W  count of advanced instructions.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- States:
  - FETCH: imem_req=1 and imem_addr=pc.
  - HOLD: imem_req=0 and instr_valid=1.
- Reset: state=FETCH, pc=RESET_PC, instr=32'h0, instr_valid=0, retired=0. imem_req is 1 in the first cycle after rst deasserts. imem_ack is ignored while rst=1.
- FETCH → HOLD: when imem_ack=1, instr<=imem_rdata at the same edge. instr_valid=1 from the next cycle. Minimum latency from request to valid is 1 cycle (zero-wait memory). A wait-state memory holds FETCH with req high and the address stable.
- HOLD → FETCH: when advance=1, the same edge sets pc<=next_pc, instr_valid<=0, retired<=retired+1 (wraps modulo 2^CNT_W). One-instruction throughput with zero-wait memory is 2 cycles.
- Ignored inputs: advance outside HOLD; imem_ack outside FETCH. instr is unchanged in both cases.
- next_pc, evaluated in priority order:
  - jump=1: pc + (sext(instr[25:0]) << 2).
  - else beq=1 and zero=1: pc + (sext(instr[23:5]) << 2).
  - else bne=1 and zero=0: pc + (sext(instr[23:5]) << 2).
  - else: pc + 4.
- If beq and bne are both high, beq takes precedence.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W. Wrap-around is legal and not flagged. pc[1:0] stays 2'b00 always.
- opcode and instr are stable for the whole of HOLD. jump/beq/bne/zero are sampled only on the advance edge.
- Reset mid-operation (FETCH or HOLD) returns to the reset state on the next edge. An outstanding request is abandoned, and the memory must not deliver a stale ack after reset.

Decomposition:
- Shared package (core_pkg): OPC_W=11, INSTR_W=32, opcode field positions [31:21], B imm field [25:0], CB imm field [23:5], fetch state enum {FETCH, HOLD}.
- One natural sub-module: branch_target. It is combinational and takes pc, instr, jump, beq, bne, zero to produce next_pc. It is reused by any later pipelined core.

Test Plan:
- Reset then zero-wait memory returning 32'hF8400000 for addr 0 → req high at cycle 1; instr_valid at cycle 2; opcode=11'b11111000010; pc=0.
- Sequential flow: advance with no branch inputs, 3 times → pc goes 0 → 4 → 8 → 12; retired=3.
- B with imm26=26'h3FFFFFE at pc=0x10 and jump=1 on advance → next pc=0x08 (negative offset). Then CBZ imm19=3 with beq=1, zero=1 → pc+12. Same CBZ with zero=0 → pc+4.
- CBNZ imm19=2 with bne=1, zero=0 → pc+8. Set beq=bne=1 with zero=1 → beq path taken.
- Wait-state memory with ack delayed 3 cycles; advance pulsed during FETCH → req and addr held stable; advance ignored (pc and retired unchanged); instr latched only on the ack cycle.
- rst asserted in HOLD with pc=0x40 and in FETCH with ack high in the same cycle → next cycle pc=RESET_PC, instr_valid=0, retired=0, instr=0. Also: pc=64'hFFFFFFFFFFFFFFFC with advance → pc wraps to 0.
